// File: rtl/neck_diff_calc.sv
// Block-averages ADC samples and produces saturated 1st/2nd/3rd-order differences
// of the averaged stream for the neck-detection judge.
module neck_diff_calc #(
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned OUT_W    = 13
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     adc_valid,
  input  logic [DATA_W-1:0]        adc_data,
  output logic signed [OUT_W-1:0]  first_order_data,
  output logic signed [OUT_W-1:0]  second_order_data,
  output logic signed [OUT_W-1:0]  third_order_data,
  output logic                     en_judge,
  output logic                     sat_flag
);

  localparam int unsigned ACC_W = DATA_W + AVG_LOG2;
  localparam int unsigned D1_W  = DATA_W + 2;
  localparam int unsigned D2_W  = DATA_W + 3;
  localparam int unsigned D3_W  = DATA_W + 4;

  localparam logic signed [D3_W-1:0] OUT_MAX = D3_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [D3_W-1:0] OUT_MIN = ~OUT_MAX;

  logic [ACC_W-1:0]             acc_q, acc_d;
  logic [AVG_LOG2-1:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]            avg_q, avg_d;
  logic                         avg_vld_q, avg_vld_d;
  logic [DATA_W-1:0]            avg1_q, avg1_d;
  logic signed [D1_W-1:0]       d1h_q, d1h_d;
  logic signed [D2_W-1:0]       d2h_q, d2h_d;
  logic [1:0]                   warm_q, warm_d;
  logic signed [OUT_W-1:0]      fo_q, fo_d, so_q, so_d, to_q, to_d;
  logic                         en_q, en_d, sat_q, sat_d;

  logic [ACC_W-1:0]             sum_c;
  logic signed [D1_W-1:0]       d1_c;
  logic signed [D2_W-1:0]       d2_c;
  logic signed [D3_W-1:0]       d3_c;

  function automatic logic signed [OUT_W-1:0] clamp(input logic signed [D3_W-1:0] v);
    if (v > OUT_MAX)      return OUT_MAX[OUT_W-1:0];
    else if (v < OUT_MIN) return OUT_MIN[OUT_W-1:0];
    else                  return v[OUT_W-1:0];
  endfunction

  function automatic logic is_sat(input logic signed [D3_W-1:0] v);
    return (v > OUT_MAX) || (v < OUT_MIN);
  endfunction

  // History keeps the unsaturated values so later orders stay exact.
  always_comb begin
    sum_c = acc_q + ACC_W'(adc_data);
    d1_c  = $signed(D1_W'(avg_q)) - $signed(D1_W'(avg1_q));
    d2_c  = D2_W'(d1_c) - D2_W'(d1h_q);
    d3_c  = D3_W'(d2_c) - D3_W'(d2h_q);
  end

  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    avg_d     = avg_q;
    avg_vld_d = 1'b0;
    avg1_d    = avg1_q;
    d1h_d     = d1h_q;
    d2h_d     = d2h_q;
    warm_d    = warm_q;
    fo_d      = fo_q;
    so_d      = so_q;
    to_d      = to_q;
    en_d      = 1'b0;
    sat_d     = 1'b0;
    if (clear) begin
      acc_d  = '0;
      cnt_d  = '0;
      avg1_d = '0;
      d1h_d  = '0;
      d2h_d  = '0;
      warm_d = '0;
    end else begin
      if (adc_valid) begin
        cnt_d = cnt_q + AVG_LOG2'(1);
        if (cnt_q == '1) begin
          acc_d     = '0;
          avg_d     = DATA_W'(sum_c >> AVG_LOG2);
          avg_vld_d = 1'b1;
        end else begin
          acc_d = sum_c;
        end
      end
      if (avg_vld_q) begin
        avg1_d = avg_q;
        d1h_d  = d1_c;
        d2h_d  = d2_c;
        // Warm-up counts prior averages; the 4th average fills d3's window.
        if (warm_q == 2'd3) begin
          fo_d  = clamp(D3_W'(d1_c));
          so_d  = clamp(D3_W'(d2_c));
          to_d  = clamp(d3_c);
          en_d  = 1'b1;
          sat_d = is_sat(D3_W'(d1_c)) | is_sat(D3_W'(d2_c)) | is_sat(d3_c);
        end else begin
          warm_d = warm_q + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      avg_q     <= '0;
      avg_vld_q <= 1'b0;
      avg1_q    <= '0;
      d1h_q     <= '0;
      d2h_q     <= '0;
      warm_q    <= '0;
      fo_q      <= '0;
      so_q      <= '0;
      to_q      <= '0;
      en_q      <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      avg_q     <= avg_d;
      avg_vld_q <= avg_vld_d;
      avg1_q    <= avg1_d;
      d1h_q     <= d1h_d;
      d2h_q     <= d2h_d;
      warm_q    <= warm_d;
      fo_q      <= fo_d;
      so_q      <= so_d;
      to_q      <= to_d;
      en_q      <= en_d;
      sat_q     <= sat_d;
    end
  end

  assign first_order_data  = fo_q;
  assign second_order_data = so_q;
  assign third_order_data  = to_q;
  assign en_judge          = en_q;
  assign sat_flag          = sat_q;

endmodule

// File: tb/tb_neck_diff_calc.sv
// Bench for neck_diff_calc: directed scenarios plus random traffic, each cycle
// compared against a block-average / finite-difference reference model.
module tb_neck_diff_calc;

  logic               clk = 1'b0;
  logic               rst_n, clear, adc_valid;
  logic [11:0]        adc_data;
  logic signed [12:0] fo, so, to;
  logic               en_judge, sat_flag;

  int n_pass = 0, n_chk = 0, n_fail = 0;
  int pulses = 0;

  // reference model state
  int m_sum, m_cnt, b_val;
  bit b_vld;
  int hist[$];
  int e_d1, e_d2, e_d3;
  bit e_en, e_sat;

  always #5 clk = ~clk;

  neck_diff_calc dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .clear             (clear),
    .adc_valid         (adc_valid),
    .adc_data          (adc_data),
    .first_order_data  (fo),
    .second_order_data (so),
    .third_order_data  (to),
    .en_judge          (en_judge),
    .sat_flag          (sat_flag)
  );

  function automatic int clampi(input int v);
    if (v > 4095)  return 4095;
    if (v < -4096) return -4096;
    return v;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_flush(input bit zero_out);
    m_sum = 0; m_cnt = 0; b_vld = 0;
    hist.delete();
    e_en = 0; e_sat = 0;
    if (zero_out) begin e_d1 = 0; e_d2 = 0; e_d3 = 0; end
  endtask

  // One clock edge of the reference: finish the pending average, then accept the sample.
  task automatic model_edge(input bit v, input int d, input bit c);
    int r1, r2, r3;
    e_en = 0; e_sat = 0;
    if (c) begin
      model_flush(0);
    end else begin
      if (b_vld) begin
        hist.push_front(b_val);
        if (hist.size() > 4) void'(hist.pop_back());
        if (hist.size() == 4) begin
          r1 = hist[0] - hist[1];
          r2 = hist[0] - 2 * hist[1] + hist[2];
          r3 = hist[0] - 3 * hist[1] + 3 * hist[2] - hist[3];
          e_d1 = clampi(r1); e_d2 = clampi(r2); e_d3 = clampi(r3);
          e_en = 1;
          e_sat = (r1 != e_d1) || (r2 != e_d2) || (r3 != e_d3);
        end
      end
      b_vld = 0;
      if (v) begin
        m_sum += d; m_cnt++;
        if (m_cnt == 4) begin
          b_val = m_sum / 4; b_vld = 1; m_sum = 0; m_cnt = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("en_judge", 32'(en_judge), 32'(e_en));
    chk("sat_flag", 32'(sat_flag), 32'(e_sat));
    chk("first", 32'(fo), e_d1);
    chk("second", 32'(so), e_d2);
    chk("third", 32'(to), e_d3);
    if (en_judge) pulses++;
  endtask

  task automatic cycle(input bit v, input int d, input bit c);
    adc_valid = v; adc_data = 12'(d); clear = c;
    @(posedge clk); #1;
    model_edge(v, d, c);
    check_all();
  endtask

  task automatic block(input int val);
    for (int i = 0; i < 4; i++) cycle(1, val, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0);
  endtask

  initial begin
    rst_n = 0; clear = 0; adc_valid = 0; adc_data = '0;
    model_flush(1);
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1;

    // constant input: exactly one strobe, all zero differences
    pulses = 0;
    for (int i = 0; i < 16; i++) cycle(1, 100, 0);
    chk("const_no_early", 32'(pulses), 0);
    idle(4);
    chk("const_pulses", 32'(pulses), 1);

    // linear ramp, then a steeper step
    cycle(0, 0, 1);
    block(100); block(110); block(120); block(130);
    idle(2);
    chk("ramp_d1", 32'(fo), 10);
    block(150);
    idle(2);
    chk("ramp2_d1", 32'(fo), 20);
    chk("ramp2_d2", 32'(so), 10);
    chk("ramp2_d3", 32'(to), 10);

    // saturation on all three orders
    cycle(0, 0, 1);
    block(0); block(4095); block(0); block(4095);
    cycle(0, 0, 0);
    chk("sat_flag_pulse", 32'(sat_flag), 1);
    idle(2);
    chk("sat_d3_hold", 32'(to), 4095);

    // clear mid-block together with a sample: sample dropped, outputs held
    cycle(1, 300, 0); cycle(1, 300, 0);
    cycle(1, 999, 1);
    pulses = 0;
    for (int i = 0; i < 16; i++) cycle(1, 200, 0);
    chk("clr_hold_d1", 32'(fo), 4095);
    chk("clr_no_early", 32'(pulses), 0);
    idle(2);
    chk("clr_pulses", 32'(pulses), 1);
    chk("clr_new_d1", 32'(fo), 0);

    // back-to-back truncating blocks 1,2,2,2
    cycle(0, 0, 1);
    pulses = 0;
    for (int b = 0; b < 8; b++) begin
      cycle(1, 1, 0); cycle(1, 2, 0); cycle(1, 2, 0); cycle(1, 2, 0);
    end
    idle(2);
    chk("b2b_pulses", 32'(pulses), 5);

    // async reset between strobes after a non-zero result
    cycle(0, 0, 1);
    block(10); block(20); block(40); block(80);
    idle(2);
    chk("pre_rst_d3", 32'(to), 10);
    cycle(1, 5, 0); cycle(1, 5, 0);
    adc_valid = 0; clear = 0;
    #3 rst_n = 0;
    #1;
    model_flush(1);
    check_all();
    #2 rst_n = 1;
    pulses = 0;
    for (int i = 0; i < 15; i++) cycle(1, 7, 0);
    idle(3);
    chk("rst_no_spurious", 32'(pulses), 0);
    cycle(1, 7, 0);
    idle(3);
    chk("rst_pulses", 32'(pulses), 1);

    // random traffic with occasional clears and extreme samples
    for (int i = 0; i < 600; i++) begin
      int d;
      bit v, c;
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 79) == 0);
      case ($urandom_range(0, 3))
        0:       d = 0;
        1:       d = 4095;
        default: d = int'($urandom_range(0, 4095));
      endcase
      cycle(v, d, c);
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/neck_diff_calc.md
Name: neck_diff_calc

Overview:
- Upstream feeder for the neck-detection judge in the welding-power controller.
- Takes raw arc-voltage ADC samples with a valid strobe and block-averages them to cut ripple.
- Produces saturated signed 13-bit first-, second- and third-order differences of the averaged stream, plus a one-cycle en_judge strobe.
- Its outputs drive the judge's en_judge / first_order_data / second_order_data / third_order_data inputs directly.

Parameters:
- DATA_W, 12: ADC sample width, unsigned.
- AVG_LOG2, 2: log2 of samples per averaging block; default averages 4 samples.
- OUT_W, 13: signed output width for all three differences.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- clear  in  1  synchronous restart; flushes accumulator and history, re-enters warm-up.
- adc_valid  in  1  one-cycle strobe: adc_data is a new sample.
- adc_data  in  DATA_W  unsigned ADC sample.
- first_order_data  out  OUT_W  signed, saturated d1.
- second_order_data  out  OUT_W  signed, saturated d2.
- third_order_data  out  OUT_W  signed, saturated d3.
- en_judge  out  1  one-cycle strobe: the three outputs hold a new valid triple.
- sat_flag  out  1  set with en_judge if any of d1/d2/d3 saturated on that update.

Behaviour:
- Reset: all outputs 0, en_judge 0, sat_flag 0. Accumulator, sample counter, history registers and warm-up counter cleared.
- Accumulate stage:
  - On adc_valid, add adc_data to a DATA_W+AVG_LOG2-bit accumulator and increment an AVG_LOG2-bit sample counter.
  - On the sample that wraps the counter (2^AVG_LOG2-th), at the next edge: avg = (acc + adc_data) >> AVG_LOG2, truncated toward zero; accumulator restarts at 0; avg_valid asserts for one cycle.
- Difference stage, on avg_valid:
  - d1 = avg[n] - avg[n-1], 14-bit signed internal.
  - d2 = d1[n] - d1[n-1], 15-bit signed internal.
  - d3 = d2[n] - d2[n-1], 16-bit signed internal.
  - History registers keep the unsaturated internal values.
  - Outputs take each value saturated to [-4096, +4095] and register it.
- Latency: adc_valid carrying the block-completing sample at edge T → avg at T+1 → outputs and en_judge at T+2.
- en_judge is high exactly one cycle per averaged value. Outputs hold between strobes.
- Warm-up:
  - A 2-bit counter counts averaged values since reset/clear, saturating at 3.
  - d3 needs avg[n..n-3], so history registers update from the first averaged value.
  - en_judge and output updates are suppressed until the 4th averaged value; the first strobe follows the 4th averaged value.
- Back-to-back adc_valid every cycle is supported; no backpressure, no sample drop.
- clear:
  - Same effect as reset except outputs hold their last values.
  - en_judge is forced 0 that cycle and the in-flight pipeline stage is discarded.
  - clear together with adc_valid: clear wins, the sample is dropped.
- clear or reset mid-block: the partial accumulator is discarded; the next sample starts a new block.
- sat_flag is valid only in the cycle en_judge is high; 0 otherwise.

Test Plan:
- Constant input: 16 samples of 100 → single en_judge pulse 2 clocks after the 16th adc_valid; d1=d2=d3=0; sat_flag=0. No en_judge before that.
- Linear ramp: 4 samples each of 100, 110, 120, 130 → first strobe gives d1=+10, d2=0, d3=0. Add a block of 150 → d1=+20, d2=+10, d3=+10.
- Saturation: 4-sample blocks averaging 0, 4095, 0, 4095 → first strobe gives first=+4095, second=+4095 (raw 8190), third=+4095 (raw 16380), sat_flag=1.
- Truncation and back-to-back timing: adc_valid continuously with samples 1,2,2,2 repeated → every averaged value is 1 (sum 7>>2). After warm-up, en_judge pulses exactly every 4 clocks with d1=d2=d3=0.
- clear mid-block: 2 samples, then clear asserted together with adc_valid → that sample is dropped. The next 16 samples are needed before the first en_judge; outputs keep their pre-clear values until then.
- Async reset mid-operation: deassert rst_n between two adc_valid strobes → all outputs 0 immediately. Warm-up restarts; no spurious en_judge.
